// File: rtl/branch_update_unit_if.sv
// Branch update unit bus: fetch slot, EX resolution, cache-write port,
// redirect and statistics outputs.
interface branch_update_unit_if;
  logic        Stall;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic        IF_PCMatch;
  logic [33:0] IF_PPC_CB;
  logic        EX_Resolve;
  logic        EX_Taken;
  logic [31:0] EX_Target;
  logic        WE;
  logic [31:0] WAddr;
  logic [31:0] Data;
  logic [1:0]  Instr_new_CB;
  logic        Mispredict;
  logic [31:0] Redirect_PC;
  logic [15:0] BranchCount;
  logic [15:0] MissCount;

  modport master (
    output Stall, IF_Valid, IF_PC, IF_PCMatch, IF_PPC_CB,
           EX_Resolve, EX_Taken, EX_Target,
    input  WE, WAddr, Data, Instr_new_CB, Mispredict, Redirect_PC,
           BranchCount, MissCount
  );

  modport slave (
    input  Stall, IF_Valid, IF_PC, IF_PCMatch, IF_PPC_CB,
           EX_Resolve, EX_Taken, EX_Target,
    output WE, WAddr, Data, Instr_new_CB, Mispredict, Redirect_PC,
           BranchCount, MissCount
  );
endinterface

// File: rtl/branch_update_unit.sv
// Branch update unit: carries prediction info from fetch through ID/EX,
// checks it against the EX resolution, and emits a registered
// prediction-cache write, a mispredict redirect and hit/miss statistics.
module branch_update_unit (
  input  logic                  Clk,
  input  logic                  Rst,
  branch_update_unit_if.slave   bus
);

  logic        id_valid, id_match;
  logic [31:0] id_pc, id_ppc;
  logic [1:0]  id_cb;
  logic        ex_valid, ex_match;
  logic [31:0] ex_pc, ex_ppc;
  logic [1:0]  ex_cb;

  logic        pred_taken;
  logic        accept;
  logic        mispredict_now;
  logic        write_now;
  logic [1:0]  new_cb;
  logic [31:0] write_data;
  logic [31:0] redirect_now;

  logic        we_q;
  logic [31:0] waddr_q;
  logic [31:0] data_q;
  logic [1:0]  cb_q;
  logic        mispredict_q;
  logic [31:0] redirect_q;
  logic [15:0] branch_count_q;
  logic [15:0] miss_count_q;

  // Resolution check: prediction vs actual outcome, and the cache update it implies
  always_comb begin
    pred_taken     = ex_match & ex_cb[1];
    accept         = bus.EX_Resolve & ex_valid & ~bus.Stall;
    mispredict_now = accept &
                     ((bus.EX_Taken != pred_taken) |
                      (bus.EX_Taken & pred_taken & (bus.EX_Target != ex_ppc)));
    // a miss that falls through has nothing worth caching
    write_now      = accept & (ex_match | bus.EX_Taken);
    if (!ex_match)
      new_cb = 2'b10;
    else if (bus.EX_Taken)
      new_cb = (ex_cb == 2'b11) ? 2'b11 : ex_cb + 2'b01;
    else
      new_cb = (ex_cb == 2'b00) ? 2'b00 : ex_cb - 2'b01;
    write_data   = bus.EX_Taken ? bus.EX_Target : ex_ppc;
    redirect_now = bus.EX_Taken ? bus.EX_Target : ex_pc + 32'd4;
  end

  // ID/EX prediction pipeline with wrong-path flush
  always_ff @(posedge Clk) begin
    if (Rst) begin
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else begin
      if (!bus.Stall) begin
        id_valid <= bus.IF_Valid;
        id_pc    <= bus.IF_PC;
        id_match <= bus.IF_PCMatch;
        id_ppc   <= bus.IF_PPC_CB[33:2];
        id_cb    <= bus.IF_PPC_CB[1:0];
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_match <= id_match;
        ex_ppc   <= id_ppc;
        ex_cb    <= id_cb;
      end
      // the fetch overlapping the redirect cycle is still wrong-path
      if (mispredict_q)
        id_valid <= 1'b0;
      if (mispredict_now) begin
        id_valid <= 1'b0;
        ex_valid <= 1'b0;
      end
    end
  end

  // Registered cache-write port and mispredict redirect
  always_ff @(posedge Clk) begin
    if (Rst) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      cb_q         <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      we_q         <= write_now;
      mispredict_q <= mispredict_now;
      if (write_now) begin
        waddr_q <= ex_pc;
        data_q  <= write_data;
        cb_q    <= new_cb;
      end
      if (mispredict_now)
        redirect_q <= redirect_now;
    end
  end

  // Saturating branch / mispredict statistics
  always_ff @(posedge Clk) begin
    if (Rst) begin
      branch_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      if (accept && branch_count_q != '1)
        branch_count_q <= branch_count_q + 16'd1;
      if (mispredict_now && miss_count_q != '1)
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign bus.WE           = we_q;
  assign bus.WAddr        = waddr_q;
  assign bus.Data         = data_q;
  assign bus.Instr_new_CB = cb_q;
  assign bus.Mispredict   = mispredict_q;
  assign bus.Redirect_PC  = redirect_q;
  assign bus.BranchCount  = branch_count_q;
  assign bus.MissCount    = miss_count_q;

endmodule

// File: tb/tb_branch_update_unit.sv
// Self-checking bench for branch_update_unit: directed vector table,
// hand-written stall / flush / reset sequences, then random stimulus
// against a behavioural reference model.
module tb_branch_update_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_update_unit_if bus ();

  branch_update_unit dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Stall      = 1'b0;
    bus.IF_Valid   = 1'b0;
    bus.IF_PC      = '0;
    bus.IF_PCMatch = 1'b0;
    bus.IF_PPC_CB  = '0;
    bus.EX_Resolve = 1'b0;
    bus.EX_Taken   = 1'b0;
    bus.EX_Target  = '0;
  endtask

  // present one instruction in the fetch slot for one edge
  task automatic fetch(input logic [31:0] pc, input logic m, input logic [31:0] ppc, input logic [1:0] cb);
    bus.IF_Valid   = 1'b1;
    bus.IF_PC      = pc;
    bus.IF_PCMatch = m;
    bus.IF_PPC_CB  = {ppc, cb};
    tick();
    bus.IF_Valid   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    bus.WE, 0);
    check({tag, "_waddr"}, bus.WAddr, 0);
    check({tag, "_data"},  bus.Data, 0);
    check({tag, "_cb"},    bus.Instr_new_CB, 0);
    check({tag, "_mis"},   bus.Mispredict, 0);
    check({tag, "_redir"}, bus.Redirect_PC, 0);
    check({tag, "_bc"},    bus.BranchCount, 0);
    check({tag, "_mc"},    bus.MissCount, 0);
  endtask

  typedef struct {
    logic        m;
    logic [31:0] pc;
    logic [31:0] ppc;
    logic [1:0]  cb;
    logic        t;
    logic [31:0] tgt;
    logic        e_we;
    logic [31:0] e_data;
    logic [1:0]  e_cb;
    logic        e_mis;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vt[8];

  // behavioural reference: each in-flight instruction as a record, ID then EX
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        m;
    bit [31:0] ppc;
    bit [1:0]  cb;
  } slot_t;

  slot_t       m_id, m_ex;
  bit          m_we, m_mis;
  bit [31:0]   m_waddr, m_data, m_redir;
  bit [1:0]    m_cb;
  int          m_bc, m_mc;

  task automatic model_step();
    bit    accept, ptaken, wrong, taken;
    int    c;
    slot_t nid, nex;
    if (rst) begin
      m_id = '{default: 0};
      m_ex = '{default: 0};
      m_we = 0; m_mis = 0; m_waddr = 0; m_data = 0; m_redir = 0; m_cb = 0;
      m_bc = 0; m_mc = 0;
      return;
    end
    taken  = bus.EX_Taken;
    accept = bus.EX_Resolve && m_ex.v && !bus.Stall;
    ptaken = m_ex.m && m_ex.cb[1];
    wrong  = accept && ((taken != ptaken) || (taken && ptaken && bus.EX_Target != m_ex.ppc));
    m_we   = 0;
    if (accept) begin
      if (m_ex.m || taken) begin
        m_we    = 1;
        m_waddr = m_ex.pc;
        m_data  = taken ? bus.EX_Target : m_ex.ppc;
        c = m_ex.cb;
        if (!m_ex.m)   c = 2;
        else if (taken) c = (c + 1 > 3) ? 3 : c + 1;
        else            c = (c - 1 < 0) ? 0 : c - 1;
        m_cb = 2'(c);
      end
      m_bc = (m_bc + 1 > 65535) ? 65535 : m_bc + 1;
      if (wrong) begin
        m_mc    = (m_mc + 1 > 65535) ? 65535 : m_mc + 1;
        m_redir = taken ? bus.EX_Target : m_ex.pc + 32'd4;
      end
    end
    nid = m_id;
    nex = m_ex;
    if (!bus.Stall) begin
      nex = m_id;
      nid = '{v: bus.IF_Valid, pc: bus.IF_PC, m: bus.IF_PCMatch,
              ppc: bus.IF_PPC_CB[33:2], cb: bus.IF_PPC_CB[1:0]};
    end
    if (m_mis) nid.v = 0;
    if (wrong) begin
      nid.v = 0;
      nex.v = 0;
    end
    m_id  = nid;
    m_ex  = nex;
    m_mis = wrong;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_bc, exp_mc;
    logic [31:0] ppcs[4];
    ppcs[0] = 32'h1000; ppcs[1] = 32'h2000; ppcs[2] = 32'h3000; ppcs[3] = 32'h4000;

    //          m     pc            ppc           cb     t     tgt           we    data          cb     mis   redir
    vt[0] = '{1'b0, 32'h100,      32'h0,        2'b00, 1'b1, 32'h200,      1'b1, 32'h200,      2'b10, 1'b1, 32'h200};
    vt[1] = '{1'b1, 32'h100,      32'h200,      2'b11, 1'b1, 32'h200,      1'b1, 32'h200,      2'b11, 1'b0, 32'h200};
    vt[2] = '{1'b1, 32'h100,      32'h200,      2'b10, 1'b0, 32'h999,      1'b1, 32'h200,      2'b01, 1'b1, 32'h104};
    vt[3] = '{1'b1, 32'h100,      32'h200,      2'b11, 1'b1, 32'h300,      1'b1, 32'h300,      2'b11, 1'b1, 32'h300};
    vt[4] = '{1'b1, 32'h400,      32'h200,      2'b01, 1'b1, 32'h200,      1'b1, 32'h200,      2'b10, 1'b1, 32'h200};
    vt[5] = '{1'b1, 32'h600,      32'h500,      2'b00, 1'b0, 32'h700,      1'b1, 32'h500,      2'b00, 1'b0, 32'h200};
    vt[6] = '{1'b0, 32'h800,      32'h0,        2'b00, 1'b0, 32'h900,      1'b0, 32'h0,        2'b00, 1'b0, 32'h200};
    vt[7] = '{1'b1, 32'hFFFFFFFC, 32'h10,       2'b10, 1'b0, 32'h20,       1'b1, 32'h10,       2'b01, 1'b1, 32'h0};

    idle();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // directed vectors: fetch, advance to EX, resolve, inspect
    exp_bc = 0;
    exp_mc = 0;
    for (int i = 0; i < 8; i++) begin
      fetch(vt[i].pc, vt[i].m, vt[i].ppc, vt[i].cb);
      tick();
      bus.EX_Resolve = 1'b1;
      bus.EX_Taken   = vt[i].t;
      bus.EX_Target  = vt[i].tgt;
      tick();
      bus.EX_Resolve = 1'b0;
      exp_bc++;
      exp_mc += int'(vt[i].e_mis);
      check($sformatf("v%0d_we", i),    bus.WE, vt[i].e_we);
      check($sformatf("v%0d_mis", i),   bus.Mispredict, vt[i].e_mis);
      check($sformatf("v%0d_redir", i), bus.Redirect_PC, vt[i].e_redir);
      check($sformatf("v%0d_bc", i),    bus.BranchCount, exp_bc);
      check($sformatf("v%0d_mc", i),    bus.MissCount, exp_mc);
      if (vt[i].e_we) begin
        check($sformatf("v%0d_waddr", i), bus.WAddr, vt[i].pc);
        check($sformatf("v%0d_data", i),  bus.Data, vt[i].e_data);
        check($sformatf("v%0d_cb", i),    bus.Instr_new_CB, vt[i].e_cb);
      end
      tick();
      check($sformatf("v%0d_we_pulse", i),  bus.WE, 0);
      check($sformatf("v%0d_mis_pulse", i), bus.Mispredict, 0);
      tick();
    end

    // flush: younger instruction in ID and the fetch during the redirect cycle are dropped
    fetch(32'h700, 1'b1, 32'h800, 2'b10);
    fetch(32'h704, 1'b0, 32'h0, 2'b00);
    bus.EX_Resolve = 1'b1;
    bus.EX_Taken   = 1'b0;
    tick();
    check("flush_mis",   bus.Mispredict, 1);
    check("flush_redir", bus.Redirect_PC, 32'h704);
    check("flush_bc",    bus.BranchCount, 9);
    check("flush_mc",    bus.MissCount, 6);
    bus.EX_Taken  = 1'b1;
    bus.EX_Target = 32'hA00;
    fetch(32'h900, 1'b0, 32'h0, 2'b00);
    check("flush_id_we", bus.WE, 0);
    check("flush_id_bc", bus.BranchCount, 9);
    tick();
    check("flush_mid_we", bus.WE, 0);
    tick();
    check("flush_fetch_we", bus.WE, 0);
    check("flush_fetch_bc", bus.BranchCount, 9);
    bus.EX_Resolve = 1'b0;
    tick();

    // stall holds the resolution until it drops, then exactly one write
    fetch(32'h140, 1'b1, 32'h240, 2'b01);
    tick();
    bus.Stall      = 1'b1;
    bus.EX_Resolve = 1'b1;
    bus.EX_Taken   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_we", k), bus.WE, 0);
      check($sformatf("stall%0d_bc", k), bus.BranchCount, 9);
    end
    bus.Stall = 1'b0;
    tick();
    bus.EX_Resolve = 1'b0;
    check("stall_rel_we",    bus.WE, 1);
    check("stall_rel_waddr", bus.WAddr, 32'h140);
    check("stall_rel_data",  bus.Data, 32'h240);
    check("stall_rel_cb",    bus.Instr_new_CB, 2'b00);
    check("stall_rel_mis",   bus.Mispredict, 0);
    check("stall_rel_bc",    bus.BranchCount, 10);
    tick();
    check("stall_once_we", bus.WE, 0);
    check("stall_once_bc", bus.BranchCount, 10);

    // reset coincident with a resolution discards it
    fetch(32'h180, 1'b0, 32'h0, 2'b00);
    tick();
    bus.EX_Resolve = 1'b1;
    bus.EX_Taken   = 1'b1;
    bus.EX_Target  = 32'h280;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.EX_Resolve = 1'b0;
    check_all_zero("rst_mid");
    fetch(32'h1C0, 1'b0, 32'h0, 2'b00);
    tick();
    bus.EX_Resolve = 1'b1;
    bus.EX_Taken   = 1'b0;
    tick();
    bus.EX_Resolve = 1'b0;
    check("post_rst_we",  bus.WE, 0);
    check("post_rst_mis", bus.Mispredict, 0);
    check("post_rst_bc",  bus.BranchCount, 1);
    check("post_rst_mc",  bus.MissCount, 0);
    tick();

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst            = (n == 0) || ($urandom_range(99) == 0);
      bus.Stall      = ($urandom_range(3) == 0);
      bus.IF_Valid   = 1'($urandom);
      bus.IF_PC      = 32'($urandom_range(63)) << 2;
      bus.IF_PCMatch = 1'($urandom);
      bus.IF_PPC_CB  = {ppcs[$urandom_range(3)], 2'($urandom)};
      bus.EX_Resolve = ($urandom_range(9) < 6);
      bus.EX_Taken   = 1'($urandom);
      bus.EX_Target  = ppcs[$urandom_range(3)];
      model_step();
      tick();
      check("rnd_we",    bus.WE, m_we);
      check("rnd_waddr", bus.WAddr, m_waddr);
      check("rnd_data",  bus.Data, m_data);
      check("rnd_cb",    bus.Instr_new_CB, m_cb);
      check("rnd_mis",   bus.Mispredict, m_mis);
      check("rnd_redir", bus.Redirect_PC, m_redir);
      check("rnd_bc",    bus.BranchCount, m_bc);
      check("rnd_mc",    bus.MissCount, m_mc);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
